mpu_seq_ctrl: RTL
=================

# mpu_seq_ctrl

Parametrised sequencing controller for the matrix processing unit. It replaces the fixed 4-BRAM, 512-bit FSM. It decodes one host instruction at a time into BRAM enable, reset and mux-select strobes for LOAD, UNLOAD, COPY, CLEAR and ALU operations. Compared with the fixed FSM it adds:
- an instruction valid/ready handshake;
- flow-controlled host byte streams in both directions;
- a configurable ALU latency wait;
- done and error pulses.

## Interface
Parameters:
- NUM_BITS, 512: BRAM word width in bits.
- BYTE_W, 8: host byte-path width; NUM_BITS divisible by BYTE_W. DEPTH = NUM_BITS/BYTE_W.
- NUM_BRAMS, 4: BRAM count, a power of 2, at least 2. SEL_W = clog2(NUM_BRAMS).
- ALU_LAT, 1: cycles from operand select to valid ALU result, at least 0.
- CLEAR_CYCLES, 1: cycles b_rst is held, at least 1.

Ports:
- clk in 1: clock, rising edge.
- reset in 1: **asynchronous, active-high reset.**
- instr in 2*SEL_W+4: {dest[SEL_W], src[SEL_W], class[2], op[2]}.
- instr_valid in 1: instruction offered.
- instr_ready out 1: controller can accept.
- busy out 1: operation in progress.
- done out 1: one-cycle pulse on the final active cycle.
- err out 1: one-cycle pulse when an illegal instruction is accepted.
- host_in_valid in 1: host write byte present (LOAD).
- host_out_valid out 1: read byte presented to host (UNLOAD).
- host_out_ready in 1: host consumed the read byte.
- offset out clog2(DEPTH): byte index.
- aa_sel, dd_sel, bram_sel, host_out_sel out SEL_W each: mux selects.
- out_sel out 2: ALU unit select (0 add, 1 shift, 2 sub, 3 mul).
- bram_in_sel out 1: 1 = BRAM-to-BRAM path, 0 = ALU path.
- b_en, b_en1, b_rst out NUM_BRAMS each: full-word write enable, byte write enable, clear.

## Operation
- Instruction classes:
  - class 00: NOP only when instr is all zero; any other class-00 value is illegal.
  - class 01: memory. op 00 LOAD, 10 UNLOAD, 01 COPY (src to dest), 11 CLEAR.
  - class 11: ALU. dest = dest op src, and op drives out_sel.
  - class 10: reserved, illegal.
- Acceptance is instr_valid && instr_ready, and instr_ready = (state == IDLE).
  - Fields are registered at acceptance.
  - A NOP is accepted and stays in IDLE.
  - An illegal instruction pulses err for one cycle, stays in IDLE and leaves busy low.
- States: IDLE, LOAD, UNLOAD, COPY, CLEAR, ALU_WAIT, ALU_WR.
- busy = (state != IDLE). All strobes are decoded from the registered state and fields.
- LOAD:
  - offset = counter.
  - b_en1[dest] = host_in_valid.
  - counter increments on each host_in_valid cycle.
  - done and the return to IDLE occur on the accepted byte at offset DEPTH-1.
- UNLOAD:
  - host_out_sel = dest, host_out_valid = 1, offset = counter.
  - Advances on host_out_ready; offset holds while ready is low.
  - Completes on the handshake at DEPTH-1.
- COPY: one cycle of b_en[dest] = 1, bram_sel = src, bram_in_sel = 1, done = 1.
- CLEAR: b_rst[dest] = 1 for CLEAR_CYCLES cycles; done on the last of them.
- ALU:
  - aa_sel = src, dd_sel = dest, out_sel = op and bram_in_sel = 0 are held throughout.
  - ALU_WAIT lasts ALU_LAT cycles with no enables; it is skipped when ALU_LAT = 0.
  - ALU_WR is one cycle with b_en[dest] = 1 and done = 1.
- src == dest is legal for COPY and ALU.
- host_in_valid and host_out_ready are ignored outside LOAD and UNLOAD.

## Timing
- Reset is asynchronous: state goes to IDLE, counter to 0, and every output to 0 except instr_ready, which goes to 1. This applies mid-operation as well; the partial transfer is abandoned.
- The first operation cycle is the cycle after acceptance. busy rises and instr_ready falls in that cycle.
- Per-instruction duration:
  - COPY: 1 cycle.
  - CLEAR: CLEAR_CYCLES.
  - ALU: ALU_LAT+1.
  - LOAD/UNLOAD: DEPTH cycles minimum, plus one cycle per stall.
- The counter wraps to 0 at completion, never mid-transfer.
- The cycle after done is IDLE. A new instruction can be accepted that cycle, giving back-to-back throughput.
- At most one of b_en, b_en1 or b_rst is nonzero in any cycle, and it is one-hot.

## Structure
- Package mpu_pkg holds:
  - class codes, memory op codes and ALU unit codes;
  - the state enum;
  - the clog2-derived width function.
- Sub-module mpu_offset_counter: DEPTH-modulo counter with enable, last flag and asynchronous reset. It is shared by LOAD and UNLOAD.

## Test plan
Benches use NUM_BRAMS=4, NUM_BITS=512, DEPTH=64, ALU_LAT=2, CLEAR_CYCLES=1.
- Reset, then instr 0x00 with valid → busy stays 0, instr_ready stays 1, all enables 0000.
- LOAD to BRAM 2 (0x84), host_in_valid toggling every cycle → 64 pulses of b_en1 = 0100 at offsets 0..63, busy for 127 cycles, done on the 64th pulse.
- UNLOAD BRAM 3 (0xC6), host_out_ready low for 5 cycles at offset 10 → offset holds at 10 and host_out_sel = 3 throughout; completes after 69 cycles.
- COPY BRAM 0 to BRAM 1 (0x45) → one cycle with b_en = 0010, bram_sel = 0, bram_in_sel = 1 and done; then CLEAR BRAM 3 (0xC7) → b_rst = 1000 for one cycle.
- ALU SUB with dest 1, src 2 (0x6E) → aa_sel = 2, dd_sel = 1, out_sel = 2 for 3 cycles; b_en = 0010 only in the third cycle.
- Two further cases:
  - reset during LOAD at offset 20 → all outputs 0 immediately, and the next LOAD starts at offset 0;
  - instr 0x08 → err pulses once and busy stays 0.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared encodings, the sequencer state type and the width helper used by
// the matrix processing unit sequencing controller.
package mpu_pkg;

  localparam logic [1:0] CLS_NOP  = 2'b00;
  localparam logic [1:0] CLS_MEM  = 2'b01;
  localparam logic [1:0] CLS_RSVD = 2'b10;
  localparam logic [1:0] CLS_ALU  = 2'b11;

  localparam logic [1:0] MEM_LOAD   = 2'b00;
  localparam logic [1:0] MEM_COPY   = 2'b01;
  localparam logic [1:0] MEM_UNLOAD = 2'b10;
  localparam logic [1:0] MEM_CLEAR  = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SHIFT = 2'b01;
  localparam logic [1:0] ALU_SUB   = 2'b10;
  localparam logic [1:0] ALU_MUL   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_UNLOAD,
    ST_COPY,
    ST_CLEAR,
    ST_ALU_WAIT,
    ST_ALU_WR
  } mpu_state_e;

  // Bits needed to index n items; never less than one so ports stay legal.
  function automatic int clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mpu_offset_counter.sv
// Byte-offset counter for host LOAD/UNLOAD streams: counts modulo DEPTH
// while enabled and flags the final byte position.
module mpu_offset_counter #(
  parameter int DEPTH = 64,
  localparam int W = mpu_pkg::clog2w(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last
);

  localparam logic [W-1:0] LAST_VAL = W'(DEPTH - 1);

  logic [W-1:0] count_reg;

  // Wrapping only on the last byte keeps the counter at 0 between transfers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= (count_reg == LAST_VAL) ? '0 : count_reg + W'(1);
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == LAST_VAL);

endmodule

// File: rtl/mpu_seq_ctrl.sv
// Sequencing controller for the matrix processing unit: accepts one host
// instruction at a time and drives BRAM enables, clears and mux selects.
module mpu_seq_ctrl import mpu_pkg::*; #(
  parameter int NUM_BITS     = 512,
  parameter int BYTE_W       = 8,
  parameter int NUM_BRAMS    = 4,
  parameter int ALU_LAT      = 1,
  parameter int CLEAR_CYCLES = 1,
  localparam int DEPTH = NUM_BITS / BYTE_W,
  localparam int SEL_W = clog2w(NUM_BRAMS),
  localparam int OFF_W = clog2w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2*SEL_W+3:0]   instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 host_in_valid,
  output logic                 host_out_valid,
  input  logic                 host_out_ready,
  output logic [OFF_W-1:0]     offset,
  output logic [SEL_W-1:0]     aa_sel,
  output logic [SEL_W-1:0]     dd_sel,
  output logic [SEL_W-1:0]     bram_sel,
  output logic [SEL_W-1:0]     host_out_sel,
  output logic [1:0]           out_sel,
  output logic                 bram_in_sel,
  output logic [NUM_BRAMS-1:0] b_en,
  output logic [NUM_BRAMS-1:0] b_en1,
  output logic [NUM_BRAMS-1:0] b_rst
);

  localparam int WAIT_MAX = (ALU_LAT > CLEAR_CYCLES) ? ALU_LAT : CLEAR_CYCLES;
  localparam int WAIT_W   = clog2w(WAIT_MAX);
  localparam logic [WAIT_W-1:0] CLR_LAST = WAIT_W'(CLEAR_CYCLES - 1);
  localparam logic [WAIT_W-1:0] ALU_LAST = WAIT_W'((ALU_LAT > 0) ? ALU_LAT - 1 : 0);
  localparam logic [NUM_BRAMS-1:0] ONE_HOT0 = NUM_BRAMS'(1);

  mpu_state_e        state_reg;
  logic [SEL_W-1:0]  dest_reg;
  logic [SEL_W-1:0]  src_reg;
  logic [1:0]        op_reg;
  logic [WAIT_W-1:0] wait_reg;
  logic              err_reg;

  logic [SEL_W-1:0]  instr_dest;
  logic [SEL_W-1:0]  instr_src;
  logic [1:0]        instr_class;
  logic [1:0]        instr_op;

  logic              cnt_en;
  logic [OFF_W-1:0]  cnt_value;
  logic              cnt_last;
  logic [NUM_BRAMS-1:0] dest_hot;

  assign instr_dest  = instr[2*SEL_W+3 -: SEL_W];
  assign instr_src   = instr[SEL_W+3 -: SEL_W];
  assign instr_class = instr[3:2];
  assign instr_op    = instr[1:0];

  assign cnt_en = ((state_reg == ST_LOAD)   && host_in_valid) ||
                  ((state_reg == ST_UNLOAD) && host_out_ready);

  mpu_offset_counter #(.DEPTH(DEPTH)) u_offset_counter (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .count (cnt_value),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      dest_reg  <= '0;
      src_reg   <= '0;
      op_reg    <= '0;
      wait_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (instr_valid) begin
            dest_reg <= instr_dest;
            src_reg  <= instr_src;
            op_reg   <= instr_op;
            wait_reg <= '0;
            case (instr_class)
              CLS_NOP: err_reg <= (instr != '0);
              CLS_MEM: begin
                case (instr_op)
                  MEM_LOAD:   state_reg <= ST_LOAD;
                  MEM_UNLOAD: state_reg <= ST_UNLOAD;
                  MEM_COPY:   state_reg <= ST_COPY;
                  default:    state_reg <= ST_CLEAR;
                endcase
              end
              CLS_ALU: state_reg <= (ALU_LAT > 0) ? ST_ALU_WAIT : ST_ALU_WR;
              default: err_reg <= 1'b1;
            endcase
          end
        end
        ST_LOAD: begin
          if (host_in_valid && cnt_last) state_reg <= ST_IDLE;
        end
        ST_UNLOAD: begin
          if (host_out_ready && cnt_last) state_reg <= ST_IDLE;
        end
        ST_COPY: state_reg <= ST_IDLE;
        ST_CLEAR: begin
          if (wait_reg == CLR_LAST) begin
            state_reg <= ST_IDLE;
            wait_reg  <= '0;
          end else begin
            wait_reg <= wait_reg + WAIT_W'(1);
          end
        end
        ST_ALU_WAIT: begin
          if (wait_reg == ALU_LAST) begin
            state_reg <= ST_ALU_WR;
            wait_reg  <= '0;
          end else begin
            wait_reg <= wait_reg + WAIT_W'(1);
          end
        end
        ST_ALU_WR: state_reg <= ST_IDLE;
        default:   state_reg <= ST_IDLE;
      endcase
    end
  end

  assign dest_hot = ONE_HOT0 << dest_reg;

  // Strobes come straight from registered state so they line up with the
  // handshake inputs of the same cycle.
  always_comb begin
    instr_ready    = (state_reg == ST_IDLE);
    busy           = (state_reg != ST_IDLE);
    done           = 1'b0;
    host_out_valid = 1'b0;
    offset         = '0;
    aa_sel         = '0;
    dd_sel         = '0;
    bram_sel       = '0;
    host_out_sel   = '0;
    out_sel        = '0;
    bram_in_sel    = 1'b0;
    b_en           = '0;
    b_en1          = '0;
    b_rst          = '0;
    case (state_reg)
      ST_LOAD: begin
        offset = cnt_value;
        b_en1  = host_in_valid ? dest_hot : '0;
        done   = host_in_valid && cnt_last;
      end
      ST_UNLOAD: begin
        offset         = cnt_value;
        host_out_sel   = dest_reg;
        host_out_valid = 1'b1;
        done           = host_out_ready && cnt_last;
      end
      ST_COPY: begin
        b_en        = dest_hot;
        bram_sel    = src_reg;
        bram_in_sel = 1'b1;
        done        = 1'b1;
      end
      ST_CLEAR: begin
        b_rst = dest_hot;
        done  = (wait_reg == CLR_LAST);
      end
      ST_ALU_WAIT: begin
        aa_sel  = src_reg;
        dd_sel  = dest_reg;
        out_sel = op_reg;
      end
      ST_ALU_WR: begin
        aa_sel  = src_reg;
        dd_sel  = dest_reg;
        out_sel = op_reg;
        b_en    = dest_hot;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign err = err_reg;

endmodule
